// File: rtl/pong_collision.sv
// Pong collision and scoring stage: evaluates wall/paddle/goal contacts on each
// frame tick, emits a one-cycle bounce code, tracks scores and game over.
module pong_collision #(
  parameter int unsigned SCREEN_X    = 640,
  parameter int unsigned SCREEN_Y    = 480,
  parameter int unsigned PADDLE_LX   = 16,
  parameter int unsigned PADDLE_RX   = 616,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned COOLDOWN    = 8,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [7:0] ball_w,
  input  logic [7:0] ball_h,
  input  logic [9:0] lpad_y,
  input  logic [9:0] rpad_y,
  input  logic [7:0] pad_h,
  output logic [1:0] bounce,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int unsigned EW = 11;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;

  localparam logic [EW-1:0] LPAD_L  = EW'(PADDLE_LX);
  localparam logic [EW-1:0] LPAD_R  = EW'(PADDLE_LX + PADDLE_W);
  localparam logic [EW-1:0] RPAD_L  = EW'(PADDLE_RX);
  localparam logic [EW-1:0] RPAD_R  = EW'(PADDLE_RX + PADDLE_W);
  localparam logic [CW-1:0] CNT_CD  = CW'(COOLDOWN);
  localparam logic [CW-1:0] CNT_SRV = CW'(SERVE_DELAY);
  localparam logic [SW-1:0] WIN     = SW'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_COOL  = 2'b01,
    ST_SERVE = 2'b10,
    ST_OVER  = 2'b11
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    bounce_q;
  logic [SW-1:0] score_l_q;
  logic [SW-1:0] score_r_q;
  logic          game_over_q;

  // 11-bit edge sums so right/bottom edges never wrap
  logic [EW-1:0] ball_xr, ball_yb, lpad_yb, rpad_yb;
  assign ball_xr = EW'(ball_x) + EW'(ball_w);
  assign ball_yb = EW'(ball_y) + EW'(ball_h);
  assign lpad_yb = EW'(lpad_y) + EW'(pad_h);
  assign rpad_yb = EW'(rpad_y) + EW'(pad_h);

  logic wall_hit, lpad_hit, rpad_hit, pad_hit, goal_l, goal_r, goal_any;
  assign wall_hit = (ball_y == 10'd0) || (ball_yb >= EW'(SCREEN_Y));
  assign lpad_hit = (EW'(ball_y) < lpad_yb) && (ball_yb > EW'(lpad_y)) &&
                    (EW'(ball_x) < LPAD_R) && (ball_xr > LPAD_L);
  assign rpad_hit = (EW'(ball_y) < rpad_yb) && (ball_yb > EW'(rpad_y)) &&
                    (EW'(ball_x) < RPAD_R) && (ball_xr > RPAD_L);
  assign pad_hit  = lpad_hit || rpad_hit;
  assign goal_l   = ball_xr >= EW'(SCREEN_X);
  assign goal_r   = (ball_x == 10'd0) && !goal_l;
  assign goal_any = goal_l || goal_r;

  logic [SW-1:0] score_l_inc, score_r_inc;
  logic [CW-1:0] cnt_dec;
  logic          goal_wins;
  assign score_l_inc = score_l_q + SW'(1);
  assign score_r_inc = score_r_q + SW'(1);
  assign cnt_dec     = cnt_q - CW'(1);
  assign goal_wins   = goal_l ? (score_l_inc == WIN) : (score_r_inc == WIN);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_SERVE;
      cnt_q       <= CNT_SRV;
      bounce_q    <= 2'b00;
      score_l_q   <= '0;
      score_r_q   <= '0;
      game_over_q <= 1'b0;
    end else begin
      bounce_q <= 2'b00;
      if (tick) begin
        case (state_q)
          ST_PLAY, ST_COOL: begin
            if (goal_any) begin
              bounce_q <= 2'b11;
              if (goal_l) score_l_q <= score_l_inc;
              else        score_r_q <= score_r_inc;
              if (goal_wins) begin
                state_q     <= ST_OVER;
                game_over_q <= 1'b1;
              end else begin
                state_q <= ST_SERVE;
                cnt_q   <= CNT_SRV;
              end
            end else if (state_q == ST_PLAY) begin
              // paddle wins over wall at corners
              if (pad_hit || wall_hit) begin
                bounce_q <= pad_hit ? 2'b01 : 2'b10;
                state_q  <= ST_COOL;
                cnt_q    <= CNT_CD;
              end
            end else begin
              cnt_q <= cnt_dec;
              if (cnt_dec == '0) state_q <= ST_PLAY;
            end
          end
          ST_SERVE: begin
            cnt_q <= cnt_dec;
            if (cnt_dec == '0) state_q <= ST_PLAY;
          end
          default: ;
        endcase
      end
    end
  end

  assign bounce    = bounce_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;
  assign state     = state_q;

endmodule
